seq_add64: RTL

SEQ_ADD64 -- requirements
Module: seq_add64

---
 rtl/seq_add64.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_add64.sv
// seq_add64: multi-cycle adder that streams 16*NSLICE-bit operands through one shared cla16.
// Optional macro SEQ_ADD_SUB_EN adds the sub port and a - b support.

module cla16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        c_msb
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [16:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Group generate/propagate for four 4-bit lookahead groups
  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end

  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    c[16] = gc[4];
  end

  assign s     = p ^ c[15:0];
  assign cout  = c[16];
  assign c_msb = c[15];

endmodule

module seq_add64 #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*NSLICE-1:0]  a,
  input  logic [16*NSLICE-1:0]  b,
  input  logic                  ci,
`ifdef SEQ_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [16*NSLICE-1:0]  sum,
  output logic                  co,
  output logic                  ovf
);

  localparam int W  = 16 * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [KW-1:0]   k;
  logic            carry;
  logic [15:0]     slice_a;
  logic [15:0]     slice_b;
  logic [15:0]     slice_s;
  logic            slice_co;
  logic            slice_cmsb;

  assign slice_a = op_a[{k, 4'b0000} +: 16];

`ifdef SEQ_ADD_SUB_EN
  logic op_sub;
  assign slice_b = op_sub ? ~op_b[{k, 4'b0000} +: 16] : op_b[{k, 4'b0000} +: 16];
`else
  assign slice_b = op_b[{k, 4'b0000} +: 16];
`endif

  cla16 u_cla (
    .x     (slice_a),
    .y     (slice_b),
    .cin   (carry),
    .s     (slice_s),
    .cout  (slice_co),
    .c_msb (slice_cmsb)
  );

  // One slice per RUN cycle; the top slice's carries give co and ovf for the full word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      k     <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
      op_sub <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_ADD_SUB_EN
            op_sub <= sub;
            carry  <= sub ? 1'b1 : ci;
`else
            carry  <= ci;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[{k, 4'b0000} +: 16] <= slice_s;
          carry <= slice_co;
          k     <= k + 1'b1;
          if (k == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            co    <= slice_co;
            ovf   <= slice_co ^ slice_cmsb;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
